// File: rtl/int2float_arbiter.sv
// Round-robin sequencer sharing one combinational int-to-float converter core
// between NREQ requesters, with a holding stage and a small in-order response FIFO.
module int2float_arbiter #(
    parameter int NREQ   = 4,
    parameter int TAGW   = 4,
    parameter int ODEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*11-1:0]       req_x,
    input  logic [NREQ*TAGW-1:0]     req_tag,
    output logic [10:0]              conv_x,
    input  logic [6:0]               conv_y,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [6:0]               rsp_y,
    output logic [$clog2(NREQ)-1:0]  rsp_src,
    output logic [TAGW-1:0]          rsp_tag,
    output logic                     busy,
    output logic [15:0]              done_cnt
);

    localparam int SW = $clog2(NREQ);
    localparam int AW = $clog2(ODEPTH);
    localparam int CW = $clog2(ODEPTH + 1);

    // Returns {found, index} of the first set valid bit at or after p, wrapping.
    function automatic logic [SW:0] rr_pick(input logic [NREQ-1:0] v, input logic [SW-1:0] p);
        logic [SW:0]   r;
        logic [SW-1:0] sel;
        int            idx;
        r = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NREQ;
            sel = SW'(idx);
            if (v[sel]) begin
                r = {1'b1, sel};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    logic               s1_v_r;
    logic [10:0]        s1_x_r;
    logic [SW-1:0]      s1_src_r;
    logic [TAGW-1:0]    s1_tag_r;
    logic [SW-1:0]      ptr_r;
    logic [6:0]         fifo_y_r   [ODEPTH];
    logic [SW-1:0]      fifo_src_r [ODEPTH];
    logic [TAGW-1:0]    fifo_tag_r [ODEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [CW-1:0]      fifo_cnt_r;
    logic [15:0]        done_cnt_r;

    logic               pop_s;
    logic               push_s;
    logic               can_load_s;
    logic               found_s;
    logic [SW-1:0]      win_s;
    logic [SW-1:0]      ptr_nxt_s;
    logic               accept_s;
    logic [10:0]        acc_x_s;
    logic [TAGW-1:0]    acc_tag_s;

    assign rsp_valid  = (fifo_cnt_r != '0);
    assign pop_s      = rsp_valid & rsp_ready;
    // A full FIFO still accepts the S1 result when the head leaves this cycle.
    assign push_s     = s1_v_r & ((fifo_cnt_r < CW'(ODEPTH)) | pop_s);
    assign can_load_s = ~s1_v_r | push_s;
    assign busy       = s1_v_r | rsp_valid;
    assign done_cnt   = done_cnt_r;

    // Round-robin winner selection and grant generation.
    always_comb begin
        {found_s, win_s} = rr_pick(req_valid, ptr_r);
        if (!rst && found_s && can_load_s) begin
            req_ready = NREQ'(1) << win_s;
        end else begin
            req_ready = '0;
        end
        if (win_s == SW'(NREQ - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = win_s + SW'(1);
        end
        accept_s  = |(req_valid & req_ready);
        acc_x_s   = req_x[int'(win_s)*11 +: 11];
        acc_tag_s = req_tag[int'(win_s)*TAGW +: TAGW];
    end

    // Converter operand is held at zero while the stage is empty.
    always_comb begin
        if (s1_v_r) begin
            conv_x = s1_x_r;
        end else begin
            conv_x = 11'h000;
        end
    end

    // Response head driven from FIFO registers, zero when empty.
    always_comb begin
        if (rsp_valid) begin
            rsp_y   = fifo_y_r[rd_ptr_r];
            rsp_src = fifo_src_r[rd_ptr_r];
            rsp_tag = fifo_tag_r[rd_ptr_r];
        end else begin
            rsp_y   = 7'h00;
            rsp_src = '0;
            rsp_tag = '0;
        end
    end

    // Holding stage and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_r   <= 1'b0;
            s1_x_r   <= 11'h000;
            s1_src_r <= '0;
            s1_tag_r <= '0;
            ptr_r    <= '0;
        end else if (accept_s) begin
            s1_v_r   <= 1'b1;
            s1_x_r   <= acc_x_s;
            s1_src_r <= win_s;
            s1_tag_r <= acc_tag_s;
            ptr_r    <= ptr_nxt_s;
        end else if (push_s) begin
            s1_v_r   <= 1'b0;
        end else begin
            s1_v_r   <= s1_v_r;
        end
    end

    // Output FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ODEPTH; i++) begin
                fifo_y_r[i]   <= 7'h00;
                fifo_src_r[i] <= '0;
                fifo_tag_r[i] <= '0;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
        end else begin
            if (push_s) begin
                fifo_y_r[wr_ptr_r]   <= conv_y;
                fifo_src_r[wr_ptr_r] <= s1_src_r;
                fifo_tag_r[wr_ptr_r] <= s1_tag_r;
                wr_ptr_r             <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CW'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CW'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Completed-response counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt_r <= 16'h0000;
        end else if (pop_s) begin
            done_cnt_r <= done_cnt_r + 16'h0001;
        end else begin
            done_cnt_r <= done_cnt_r;
        end
    end

    int2float_arbiter_chk #(
        .NREQ   (NREQ),
        .ODEPTH (ODEPTH)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .fifo_cnt  (fifo_cnt_r)
    );

endmodule

// Structural invariants of the arbiter: grant shape and FIFO occupancy bound.
module int2float_arbiter_chk #(
    parameter int NREQ   = 4,
    parameter int ODEPTH = 2
) (
    input logic                          clk,
    input logic                          rst,
    input logic [NREQ-1:0]               req_valid,
    input logic [NREQ-1:0]               req_ready,
    input logic [$clog2(ODEPTH+1)-1:0]   fifo_cnt
);

    localparam int CW = $clog2(ODEPTH + 1);

    // Sample invariants once per cycle outside reset.
    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(req_ready))
                else $error("int2float_arbiter_chk: req_ready not one-hot %b", req_ready);
            assert ((req_ready & ~req_valid) == '0)
                else $error("int2float_arbiter_chk: grant to idle requester %b", req_ready);
            assert (fifo_cnt <= CW'(ODEPTH))
                else $error("int2float_arbiter_chk: fifo overflow count %0d", fifo_cnt);
        end
    end

endmodule

// File: doc/int2float_arbiter.md
# int2float_arbiter

Round-robin arbiter and sequencer that shares a single combinational 11-bit→7-bit integer-to-float converter core between NREQ requesters. It accepts one request per cycle through per-requester valid/ready handshakes and presents the operand to the external converter from a holding register. It captures the converter result together with the source index and tag into a small output FIFO. It sits between the requesting engines and the converter core, which is instantiated beside it and connected through `conv_x`/`conv_y`.

## Interface

Parameters:

- `NREQ`, 4: number of requesters, 2..8.
- `TAGW`, 4: per-request tag width, passed through unchanged.
- `ODEPTH`, 2: output FIFO depth, power of two, ≥2.

Ports:

- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in NREQ: request i present.
- `req_ready` out NREQ: one-hot or zero; request i accepted on the edge where valid[i]&ready[i].
- `req_x` in NREQ*11: operand of requester i at bits [11i+10:11i].
- `req_tag` in NREQ*TAGW: tag of requester i.
- `conv_x` out 11: operand to converter core.
- `conv_y` in 7: converter result, combinational from `conv_x`, same cycle.
- `rsp_valid` out 1: FIFO head valid.
- `rsp_ready` in 1: consumer accepts head.
- `rsp_y` out 7: converted value.
- `rsp_src` out clog2(NREQ): index of originating requester.
- `rsp_tag` out TAGW: tag of originating request.
- `busy` out 1: S1 valid or FIFO non-empty.
- `done_cnt` out 16: count of responses popped, wraps 0xFFFF→0.

## Operation

- Stage S1 is a holding register: s1_v, s1_x[10:0], s1_src, s1_tag.
  - `conv_x` = s1_x whenever s1_v is 1.
  - `conv_x` = 0 whenever s1_v is 0 (no toggling on idle).
- Output FIFO holds ODEPTH entries of {y, src, tag}. fifo_cnt ranges 0..ODEPTH.
- pop = rsp_valid & rsp_ready.
- s1_adv = s1_v & (fifo_cnt < ODEPTH | pop).
  - On s1_adv, {conv_y, s1_src, s1_tag} is written to the FIFO tail.
  - A push and a pop in the same cycle on a full FIFO are both legal; fifo_cnt stays ODEPTH.
- can_load = ~s1_v | s1_adv.
- Arbitration (combinational):
  - Search req_valid starting at index `ptr`, wrapping modulo NREQ. The first set bit is the winner w.
  - req_ready[w] = can_load. All other req_ready bits are 0.
  - If no req_valid bit is set, or can_load is 0, req_ready is all zero.
  - req_ready never depends on req_x or req_tag.
- On accept of requester w:
  - s1 ← {1, req_x[w], w, req_tag[w]}.
  - ptr ← (w+1) mod NREQ.
- When no accept occurs:
  - ptr holds.
  - s1_v ← 0 if s1_adv, else s1 holds.
- Requesters must keep req_x and req_tag stable while valid and not ready. The block does not require them to hold valid; withdrawal is tolerated and simply not granted.
- Responses leave in acceptance order. Nothing is dropped or duplicated.
- done_cnt increments by 1 on each pop.

Reset (rst=1 at an edge), taking effect from the next cycle:

- s1_v=0, fifo_cnt=0, FIFO pointers 0, ptr=0, done_cnt=0.
- Resulting outputs: req_ready=0 during reset, rsp_valid=0, busy=0, conv_x=0, rsp_y/rsp_src/rsp_tag=0.
- Reset mid-operation discards S1 and all FIFO contents. No response from before reset is ever emitted.
- req_ready is forced to 0 while rst=1.

## Timing

- Minimum latency: accept at edge N → FIFO write at edge N+1 → rsp_valid=1 in cycle after N+1. That is 2 edges from accept to response visible.
- Throughput: 1 request per cycle sustained while rsp_ready=1.
- rsp_y, rsp_src and rsp_tag come from FIFO registers. No combinational path from req_* or conv_y to rsp_*.
- Combinational paths:
  - rsp_ready → req_ready, via pop in s1_adv. This path is required.
  - conv_y → FIFO data input only.
- Backpressure with rsp_ready=0 stalls in this order:
  1. FIFO fills (ODEPTH responses).
  2. S1 holds one more request.
  3. req_ready drops to 0.
- At most ODEPTH+1 requests are in flight.
- Fairness: with all requesters continuously valid and no backpressure, grants rotate 0,1,…,NREQ-1,0. Each requester is granted within NREQ accepts of raising valid.

## Test plan

- **Reset values:** hold rst 3 cycles with all req_valid=1 → req_ready=0, rsp_valid=0, busy=0, conv_x=0, done_cnt=0 throughout and after release until first edge.
- **Single request:** NREQ=4, req_valid=4'b0100, x=11'h3A5, tag=5, rsp_ready=1 → accept at edge 0, rsp_valid high after edge 1 with rsp_src=2, rsp_tag=5, rsp_y equal to golden converter(11'h3A5); busy=0 after edge 2.
- **Round-robin:** all 4 valid for 8 cycles, rsp_ready=1 → rsp_src sequence 0,1,2,3,0,1,2,3, tags matching; done_cnt=8.
- **Backpressure:** rsp_ready=0, continuous requests from requester 1 → exactly ODEPTH+1=3 accepts, then req_ready=0. Raise rsp_ready → 3 responses in order, then accepts resume the same cycle rsp_ready rises.
- **Full FIFO with simultaneous push/pop:** FIFO full, S1 valid, rsp_ready=1 for 1 cycle → one pop, one push, one new accept; fifo_cnt stays 2.
- **Reset mid-flight:** 3 requests in flight, assert rst 1 cycle → no stale responses emitted; the next accepted request (x=11'h001, src 0) is the first response; done_cnt restarts from 0, and wraps from 0xFFFF to 0 (preload by 65535 pops).
